// File: rtl/frame_sync_detector_if.sv
// rtl/frame_sync_detector_if.sv - byte stream in / payload stream out bundle for frame_sync_detector (FSYNC_STATS_EN adds counters)
interface frame_sync_detector_if;
    logic [7:0]  din;
    logic        valid;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        sof;
    logic        eof;
    logic        locked;
    logic        sync_err;
`ifdef FSYNC_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    modport master (output din, valid,
                    input  dout, dout_valid, sof, eof, locked, sync_err, frame_cnt, err_cnt);
    modport slave  (input  din, valid,
                    output dout, dout_valid, sof, eof, locked, sync_err, frame_cnt, err_cnt);
`else
    modport master (output din, valid,
                    input  dout, dout_valid, sof, eof, locked, sync_err);
    modport slave  (input  din, valid,
                    output dout, dout_valid, sof, eof, locked, sync_err);
`endif
endinterface

// File: rtl/frame_sync_detector.sv
// rtl/frame_sync_detector.sv - sync byte hunt/verify/lock with flywheel and payload forwarding (optional FSYNC_STATS_EN counters)
module frame_sync_detector #(
    parameter logic [7:0] SYNC_BYTE = 8'h47,
    parameter int         FRAME_LEN = 16,
    parameter int         LOCK_CNT  = 3,
    parameter int         LOSS_CNT  = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    frame_sync_detector_if.slave  bus
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [7:0] LAST_POS = 8'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    logic [1:0] state;
    logic [7:0] pos;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;

    logic       accept;
    logic       is_sync;
    logic       sync_slot;
    logic [7:0] pos_inc;

    assign accept    = enable & bus.valid;
    assign is_sync   = (bus.din == SYNC_BYTE);
    assign sync_slot = (pos == 8'd0);
    assign pos_inc   = (pos == LAST_POS) ? 8'd0 : pos + 8'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= HUNT;
            pos            <= 8'd0;
            match_cnt      <= 4'd0;
            miss_cnt       <= 4'd0;
            bus.dout       <= 8'h00;
            bus.dout_valid <= 1'b0;
            bus.sof        <= 1'b0;
            bus.eof        <= 1'b0;
            bus.sync_err   <= 1'b0;
            bus.locked     <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            bus.sof        <= 1'b0;
            bus.eof        <= 1'b0;
            bus.sync_err   <= 1'b0;
            case (state)
                HUNT: begin
                    if (accept && is_sync) begin
                        state     <= VERIFY;
                        pos       <= 8'd1;
                        match_cnt <= 4'd1;
                    end
                end
                VERIFY: begin
                    if (accept) begin
                        if (!sync_slot) begin
                            pos <= pos_inc;
                        end else if (is_sync) begin
                            pos       <= pos_inc;
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_TGT) begin
                                state      <= LOCKED;
                                miss_cnt   <= 4'd0;
                                bus.locked <= 1'b1;
                            end
                        end else begin
                            // the failing byte is dropped, not retried as a new sync candidate
                            state     <= HUNT;
                            pos       <= 8'd0;
                            match_cnt <= 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        pos <= pos_inc;
                        if (!sync_slot) begin
                            bus.dout       <= bus.din;
                            bus.dout_valid <= 1'b1;
                            bus.sof        <= (pos == 8'd1);
                            bus.eof        <= (pos == LAST_POS);
                        end else if (is_sync) begin
                            miss_cnt <= 4'd0;
                        end else begin
                            // flywheel: a bad sync slot keeps frame timing until LOSS_CNT misses in a row
                            bus.sync_err <= 1'b1;
                            miss_cnt     <= miss_cnt + 4'd1;
                            if (miss_cnt + 4'd1 == LOSS_TGT) begin
                                state      <= HUNT;
                                pos        <= 8'd0;
                                match_cnt  <= 4'd0;
                                bus.locked <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state      <= HUNT;
                    pos        <= 8'd0;
                    match_cnt  <= 4'd0;
                    miss_cnt   <= 4'd0;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef FSYNC_STATS_EN
    logic gen_eof;
    logic gen_err;

    assign gen_eof = accept && (state == LOCKED) && !sync_slot && (pos == LAST_POS);
    assign gen_err = accept && (state == LOCKED) && sync_slot && !is_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.frame_cnt <= 16'd0;
            bus.err_cnt   <= 16'd0;
        end else begin
            if (gen_eof && bus.frame_cnt != 16'hFFFF) bus.frame_cnt <= bus.frame_cnt + 16'd1;
            if (gen_err && bus.err_cnt != 16'hFFFF)   bus.err_cnt   <= bus.err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/frame_sync_detector.md
Name: frame_sync_detector

Overview:
Downstream consumer of the self-synchronizing descrambler's byte stream. It finds a fixed sync byte at a fixed frame period, declares lock after repeated confirmation, and then forwards payload bytes with frame delimiters. It drops lock after repeated sync misses and returns to hunting. Output feeds the packet/payload layer.

Parameters:
SYNC_BYTE, 8'h47, sync byte value expected at frame position 0
FRAME_LEN, 16, frame length in bytes including the sync byte; legal range 3..256
LOCK_CNT, 3, consecutive sync matches (including the first) needed to enter LOCKED; legal range 2..15
LOSS_CNT, 3, consecutive sync misses while LOCKED needed to return to HUNT; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
enable  in  1  global stage enable; when low, all state and outputs hold except the pulse outputs
din  in  8  descrambled byte from the upstream descrambler
valid  in  1  din qualifier; a byte is accepted only when enable=1 and valid=1
dout  out  8  payload byte, registered
dout_valid  out  1  one-cycle pulse, dout holds a payload byte
sof  out  1  pulse with dout_valid on the first payload byte (frame position 1)
eof  out  1  pulse with dout_valid on the last payload byte (frame position FRAME_LEN-1)
locked  out  1  high while the state is LOCKED
sync_err  out  1  one-cycle pulse on each sync-slot mismatch while LOCKED

Behaviour:
- Reset (async, resetn=0): state=HUNT; pos=0; match_cnt=0; miss_cnt=0; dout=8'h00; dout_valid=sof=eof=sync_err=0; locked=0.
- accept = enable & valid. Nothing advances without accept.
- dout_valid, sof, eof and sync_err are cleared on every clock where no pulse is generated. dout holds its last value.
- pos: an 8-bit frame position counter. On accept, pos goes 0..FRAME_LEN-1 and then wraps to 0. Position 0 is the sync slot.
- HUNT:
  - On accept with din==SYNC_BYTE: go to VERIFY, set pos=1, set match_cnt=1.
  - Any other accepted byte is discarded and the state stays HUNT.
- VERIFY:
  - Non-sync-slot bytes advance pos and are not output.
  - Sync slot with a match: match_cnt increments. When it reaches LOCK_CNT, go to LOCKED and set miss_cnt=0.
  - Sync slot with a mismatch: go to HUNT with match_cnt=0. That byte is not re-evaluated as a sync candidate.
- LOCKED:
  - Bytes at pos 1..FRAME_LEN-1 are registered to dout with a dout_valid pulse on the next cycle, so latency is 1 clock from the accepting edge.
  - sof is asserted at pos 1; eof is asserted at pos FRAME_LEN-1.
  - Sync slot with a match: miss_cnt=0. The sync byte is never output.
  - Sync slot with a mismatch: sync_err pulses and miss_cnt increments. When miss_cnt reaches LOSS_CNT, go to HUNT with pos=0 and locked falling on the same edge. Otherwise stay LOCKED; the flywheel keeps the frame timing.
- locked is registered and equals (state==LOCKED).
- A mismatched sync byte in LOCKED is still treated as the sync slot and is not forwarded.
- If valid has gaps inside a frame, pos advances only on accepted bytes and frame timing is preserved.
- If enable is low during LOCKED, state is frozen and no pulses are generated. Resuming continues at the same pos.
- Asserting reset mid-frame aborts the frame immediately; no eof is emitted.
- Unused state encodings recover to HUNT on the next clock.

Optional Feature:
Macro FSYNC_STATS_EN.
- When defined: adds outputs frame_cnt[15:0] and err_cnt[15:0], both reset to 0.
  - frame_cnt increments on each eof pulse.
  - err_cnt increments on each sync_err pulse.
  - Both counters saturate at 16'hFFFF and hold their value through loss of lock. Only reset clears them.
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset, then a clean stream of frames [47, 00..0E] x4 with valid=1 → locked rises after the sync byte of frame 3; frame 4 emits 15 dout_valid pulses (00..0E), with sof on 00 and eof on 0E.
2. While locked, corrupt one sync byte to 8'h46 → sync_err pulses once; locked stays 1; the payload of that frame is still forwarded. The next good sync clears miss_cnt.
3. While locked, corrupt 3 consecutive sync bytes → locked falls on the third bad sync-slot edge; no dout_valid pulses afterwards until re-lock.
4. Random bytes containing an isolated 8'h47 with no repeat 16 bytes later → goes HUNT→VERIFY→HUNT; locked is never asserted.
5. Locked stream with valid deasserted every other cycle and enable low for 5 cycles mid-frame → payload order is preserved and sof/eof positions are unchanged; no pulses occur while enable=0.
6. With FSYNC_STATS_EN, run 5 locked frames plus 2 single sync errors → frame_cnt=5, err_cnt=2. Assert resetn=0 mid-frame → all outputs return to reset values asynchronously.
